spram_port_arbiter: RTL and testbench

//  Shares one single-port la_spram (1 RW port) between an independent write

---
 rtl/spram_port_arbiter.sv | 109 ++++++++++
 tb/tb_spram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_port_arbiter.sv
// Shares one single-port SRAM between a write requester and a read requester.
// It uses round-robin arbitration and returns read data through a 2-entry credited response FIFO.
module spram_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic [DW/8-1:0] wr_mask_i,
  input  logic            rd_valid_i,
  output logic            rd_ready_o,
  input  logic [AW-1:0]   rd_addr_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic            mem_ce_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wmask_o,
  output logic [DW-1:0]   mem_din_o,
  input  logic [DW-1:0]   mem_dout_i
);

  localparam int unsigned MW = DW / 8;
  localparam logic GntRd = 1'b0;
  localparam logic GntWr = 1'b1;

  logic          last_gnt_q, last_gnt_d;
  logic          inflight_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          rd_ptr_q, wr_ptr_q;
  logic [DW-1:0] fifo_q [2];

  logic          push, pop;
  logic [2:0]    occ_static, occ;
  logic          rd_ok, rd_arb;
  logic          gnt_wr, gnt_rd;

  assign rsp_valid_o = (cnt_q != 2'd0);
  assign rsp_data_o  = fifo_q[rd_ptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = inflight_q;

  assign occ_static = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign occ        = occ_static - {2'b00, pop};
  assign rd_ok      = rd_valid_i & (occ < 3'd2);
  // Arbitration sees only the pop-independent credit so wr_ready never depends on rsp_ready.
  assign rd_arb     = rd_valid_i & (occ_static < 3'd2);

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (rst_ni) begin
      gnt_wr = wr_valid_i & ~(rd_arb & (last_gnt_q == GntWr));
      gnt_rd = rd_ok & ~gnt_wr;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_wr) begin
      last_gnt_d = GntWr;
    end else if (gnt_rd) begin
      last_gnt_d = GntRd;
    end
  end

  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  assign wr_ready_o = gnt_wr;
  assign rd_ready_o = gnt_rd;
  assign mem_ce_o   = gnt_wr | gnt_rd;
  assign mem_we_o   = gnt_wr;
  assign mem_addr_o = gnt_wr ? wr_addr_i : rd_addr_i;
  assign mem_din_o  = wr_data_i;

  always_comb begin
    mem_wmask_o = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      mem_wmask_o[8*i +: 8] = {8{wr_mask_i[i]}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= GntWr;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      inflight_q <= gnt_rd;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= mem_dout_i;
  end

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter with an attached SRAM model and a response scoreboard.
module tb_spram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, mem_addr;
  logic [DW-1:0] wr_data, rsp_data, mem_wmask, mem_din, mem_dout;
  logic [3:0]    wr_mask;
  logic          rsp_valid, rsp_ready, mem_ce, mem_we;

  spram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_mask_i   (wr_mask),
    .rd_valid_i  (rd_valid),
    .rd_ready_o  (rd_ready),
    .rd_addr_i   (rd_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .mem_ce_o    (mem_ce),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wmask_o (mem_wmask),
    .mem_din_o   (mem_din),
    .mem_dout_i  (mem_dout)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Single-port SRAM model: dout registered on a read ce.
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] ref_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    mem_dout = '0;
  end

  always @(posedge clk_i) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
      else        mem_dout <= sram[mem_addr];
    end
  end

  // Scoreboard: expected read data queued at accept, compared at response handshake.
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_wmask;
  logic [DW-1:0] e;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      chk("one_grant", {31'd0, wr_ready & rd_ready}, 32'd0);
      chk("mem_ce", {31'd0, mem_ce}, {31'd0, wr_valid & wr_ready | rd_valid & rd_ready});
      if (wr_valid && wr_ready) begin
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", {22'd0, mem_addr}, {22'd0, wr_addr});
        chk("wr_din", mem_din, wr_data);
        chk("wr_wmask", mem_wmask, expand(wr_mask));
        last_wmask = mem_wmask;
        ref_mem[wr_addr] = (ref_mem[wr_addr] & ~expand(wr_mask)) | (wr_data & expand(wr_mask));
      end
      if (rd_valid && rd_ready) begin
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        chk("rd_addr", {22'd0, mem_addr}, {22'd0, rd_addr});
        exp_q.push_back(ref_mem[rd_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e);
        end
      end
    end
  end

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    bit ok = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_i);
      if (wr_ready) ok = 1'b1;
      @(posedge clk_i); #1;
    end
    wr_valid = 1'b0;
    chk("wr_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_read(input logic [9:0] a);
    bit ok = 1'b0;
    rd_valid = 1'b1; rd_addr = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_i);
      if (rd_ready) ok = 1'b1;
      @(posedge clk_i); #1;
    end
    rd_valid = 1'b0;
    chk("rd_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic read_check(input string name, input logic [9:0] a, input logic [31:0] exp);
    bit got = 1'b0;
    logic [31:0] d = '0;
    do_read(a);
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk_i);
      if (rsp_valid) begin got = 1'b1; d = rsp_data; end
      @(posedge clk_i); #1;
    end
    chk({name, "_seen"}, {31'd0, got}, 32'd1);
    chk(name, d, exp);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) begin
      @(posedge clk_i); #1;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic        wv, rv;
    logic [9:0]  wa, ra;
    logic [31:0] wd;
    logic        ewr, err, ece;
  } vec_t;
  vec_t vecs[8];

  initial begin
    // Contention table: both sides held valid, payloads change only after acceptance.
    for (int i = 0; i < 8; i++) begin
      vecs[i].wv  = 1'b1;
      vecs[i].rv  = 1'b1;
      vecs[i].wa  = 10'h10 + 10'(i / 2);
      vecs[i].wd  = 32'hA000_0000 + 32'(i / 2);
      vecs[i].ra  = 10'h10 + 10'((i + 1) / 2);
      vecs[i].ewr = (i % 2) == 1;
      vecs[i].err = (i % 2) == 0;
      vecs[i].ece = 1'b1;
    end

    // Reset with all requests asserted.
    rst_ni = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    wr_addr = '0; wr_data = '0; wr_mask = 4'hF; rd_addr = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Round-robin under contention starting with the read.
    for (int i = 0; i < 8; i++) begin
      wr_valid = vecs[i].wv; rd_valid = vecs[i].rv;
      wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_mask = 4'hF; rd_addr = vecs[i].ra;
      @(negedge clk_i);
      chk($sformatf("rr_wr_ready[%0d]", i), {31'd0, wr_ready}, {31'd0, vecs[i].ewr});
      chk($sformatf("rr_rd_ready[%0d]", i), {31'd0, rd_ready}, {31'd0, vecs[i].err});
      chk($sformatf("rr_mem_ce[%0d]", i), {31'd0, mem_ce}, {31'd0, vecs[i].ece});
      @(posedge clk_i); #1;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    drain();

    // Full write then read with two-cycle response latency.
    do_write(10'h003, 32'hDEADBEEF, 4'hF);
    do_read(10'h003);
    @(negedge clk_i);
    chk("lat_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("lat_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_n2_rsp_data", rsp_data, 32'hDEADBEEF);
    @(posedge clk_i); #1;

    // Partial byte write.
    do_write(10'h003, 32'h11223344, 4'b0011);
    chk("partial_wmask", last_wmask, 32'h0000FFFF);
    read_check("partial_data", 10'h003, 32'hDEAD3344);

    // Backpressure: FIFO credit blocks reads, writes continue.
    for (int i = 0; i < 4; i++) do_write(10'(i), 32'h1000_0000 + 32'(i), 4'hF);
    rsp_ready = 1'b0;
    do_read(10'h000);
    do_read(10'h001);
    rd_valid = 1'b1; rd_addr = 10'h002;
    wr_valid = 1'b1; wr_addr = 10'h030; wr_data = 32'hCAFE0030; wr_mask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk($sformatf("bp_rd_stall[%0d]", k), {31'd0, rd_ready}, 32'd0);
      chk($sformatf("bp_rsp_valid[%0d]", k), {31'd0, rsp_valid}, 32'd1);
      if (k == 0) chk("bp_wr_granted", {31'd0, wr_ready}, 32'd1);
      @(posedge clk_i); #1;
      wr_valid = 1'b0;
    end
    chk("bp_fifo_head", rsp_data, 32'h1000_0000);
    rsp_ready = 1'b1;
    do_read(10'h002);
    do_read(10'h003);
    drain();

    // Reset while a read is in flight.
    do_write(10'h040, 32'h5A5A_1234, 4'hF);
    do_read(10'h040);
    rst_ni = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk($sformatf("post_rst_rsp_valid[%0d]", k), {31'd0, rsp_valid}, 32'd0);
      @(posedge clk_i); #1;
    end
    read_check("post_rst_data", 10'h040, 32'h5A5A_1234);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
